// File: rtl/cla_accum_8bit.sv
// cla_adder_8bit : combinational 8-bit adder, two 4-bit carry-lookahead groups.
//   a_i, b_i [7:0] : operands
//   sum_o    [7:0] : a_i + b_i modulo 256 (carry-in fixed at 0)
//
// cla_accum_8bit : folds ACC_LEN unsigned 8-bit operands into one result and
// presents it on a valid/ready port, with a sticky unsigned overflow flag.
//   clk            : clock, all state updates on the rising edge
//   rst_n          : asynchronous active-low reset
//   clr            : synchronous clear, aborts the current accumulation
//   in_valid/in_ready/din       : operand input handshake
//   out_valid/out_ready         : result output handshake
//   acc_out [7:0]  : registered accumulator (meaningful while out_valid)
//   ovf            : sticky carry-out of bit 7 for the current result
//   busy           : state is not IDLE

module cla_adder_8bit (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  output logic [7:0] sum_o
);

  logic [7:0] g;
  logic [7:0] p;
  logic [7:0] c;

  always_comb begin
    g = a_i & b_i;
    p = a_i ^ b_i;

    // Low group: carries expanded directly from g/p with carry-in 0.
    c[0] = 1'b0;
    c[1] = g[0];
    c[2] = g[1] | (p[1] & g[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);

    // High group: same expansion, fed by the low group's carry-out.
    c[5] = g[4] | (p[4] & c[4]);
    c[6] = g[5] | (p[5] & g[4]) | (p[5] & p[4] & c[4]);
    c[7] = g[6] | (p[6] & g[5]) | (p[6] & p[5] & g[4]) | (p[6] & p[5] & p[4] & c[4]);

    sum_o = p ^ c;
  end

endmodule

module cla_accum_8bit #(
  parameter int unsigned ACC_LEN = 4,
  parameter int unsigned CNT_W   = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] din,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] acc_out,
  output logic       ovf,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ACC_LEN - 1);

  state_e           state_q, state_d;
  logic [7:0]       acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic [7:0] add_a;
  logic [7:0] add_sum;
  logic       add_carry;
  logic       accept;
  logic       xfer;

  // IDLE forces the adder's accumulator input to zero, so a new result starts
  // cleanly without having to clear acc on output transfer.
  assign add_a = (state_q == IDLE) ? '0 : acc_q;

  cla_adder_8bit u_adder (
    .a_i   (add_a),
    .b_i   (din),
    .sum_o (add_sum)
  );

  // Carry-out of bit 7 recovered from the MSBs: both set, or exactly one set
  // and the sum bit cleared (which means a carry arrived into bit 7).
  assign add_carry = (add_a[7] & din[7]) | ((add_a[7] | din[7]) & ~add_sum[7]);

  assign in_ready  = (state_q != DONE) & ~clr;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign acc_out   = acc_q;
  assign ovf       = ovf_q;

  assign accept = in_valid & in_ready;
  assign xfer   = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;

    if (clr) begin
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            acc_d   = add_sum;
            ovf_d   = add_carry;
            cnt_d   = CNT_W'(1);
            state_d = (ACC_LEN == 1) ? DONE : ACCUM;
          end
        end
        ACCUM: begin
          if (accept) begin
            acc_d = add_sum;
            ovf_d = ovf_q | add_carry;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_CNT) begin
              state_d = DONE;
            end
          end
        end
        DONE: begin
          if (xfer) begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_cla_accum_8bit.sv
// Bench for cla_accum_8bit: directed scenarios plus randomized traffic, all
// checked every cycle against a transaction-level model (running integer
// total, count of accepted operands, pending-result flag).

module tb_cla_accum_8bit;

  localparam int ACC_LEN = 4;

  logic       clk;
  logic       rst_n;
  logic       clr;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] din;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] acc_out;
  logic       ovf;
  logic       busy;

  cla_accum_8bit #(
    .ACC_LEN (ACC_LEN),
    .CNT_W   (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din       (din),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .acc_out   (acc_out),
    .ovf       (ovf),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: result = unbounded sum of the operands mod 256; overflow = that
  // unbounded sum reached 256 at any point (equivalently, at the end).
  int         m_n;
  int         m_total;
  bit         m_pend;
  logic [7:0] m_acc;
  bit         m_ovf;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_n <= 0; m_total <= 0; m_pend <= 1'b0; m_acc <= 8'h00; m_ovf <= 1'b0;
    end else if (clr) begin
      m_n <= 0; m_total <= 0; m_pend <= 1'b0; m_acc <= 8'h00; m_ovf <= 1'b0;
    end else if (m_pend) begin
      if (out_ready) begin
        m_pend  <= 1'b0;
        m_n     <= 0;
        m_total <= 0;
      end
    end else if (in_valid) begin
      m_total <= m_total + int'(din);
      m_acc   <= 8'((m_total + int'(din)) % 256);
      m_ovf   <= (m_total + int'(din)) >= 256;
      m_n     <= m_n + 1;
      if (m_n + 1 == ACC_LEN) m_pend <= 1'b1;
    end
  end

  int checks;
  int passed;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("out_valid", 32'(out_valid), 32'(m_pend));
        chk("busy",      32'(busy),      32'(m_pend || (m_n > 0)));
        chk("in_ready",  32'(in_ready),  32'(!m_pend && !clr));
        chk("acc_out",   32'(acc_out),   32'(m_acc));
        chk("ovf",       32'(ovf),       32'(m_ovf));
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one operand after 'gap' idle cycles; returns one tick after the
  // accepting edge.
  task automatic send(input logic [7:0] d, input int gap);
    logic r;
    r = 1'b0;
    in_valid = 1'b0;
    repeat (gap) step();
    in_valid = 1'b1;
    din      = d;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      r = in_ready;
      step();
      if (r) break;
    end
    chk("send_accept", 32'(r), 32'(1));
    in_valid = 1'b0;
  endtask

  // Called right after the last operand is accepted; expects out_valid at the
  // very next sample point. Returns at that negedge.
  task automatic wait_result(input string nm, input logic [7:0] ea, input logic ee);
    int lat;
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = i;
        break;
      end
    end
    chk({nm, "_valid"}, 32'(out_valid), 32'(1));
    chk({nm, "_latency"}, 32'(lat), 32'(0));
    chk({nm, "_acc"}, 32'(acc_out), 32'(ea));
    chk({nm, "_ovf"}, 32'(ovf), 32'(ee));
  endtask

  initial begin
    checks    = 0;
    passed    = 0;
    rst_n     = 1'b1;
    clr       = 1'b0;
    in_valid  = 1'b0;
    din       = 8'h00;
    out_ready = 1'b1;

    fork
      compare_loop();
    join_none

    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_busy",      32'(busy),      32'(0));
    chk("rst_acc",       32'(acc_out),   32'(8'h00));
    chk("rst_ovf",       32'(ovf),       32'(0));
    step();
    rst_n = 1'b1;
    step();

    // 1: back-to-back sum, immediate transfer
    send(8'h10, 0); send(8'h20, 0); send(8'h30, 0); send(8'h40, 0);
    wait_result("t1", 8'hA0, 1'b0);
    step();
    @(negedge clk);
    chk("t1_idle_busy", 32'(busy), 32'(0));
    step();

    // 2: wrap with overflow, then overflow must not carry into next result
    send(8'hFF, 0); send(8'h01, 0); send(8'h00, 0); send(8'h05, 0);
    wait_result("t2a", 8'h05, 1'b1);
    step();
    send(8'h01, 0); send(8'h01, 0); send(8'h01, 0); send(8'h01, 0);
    wait_result("t2b", 8'h04, 1'b0);
    step();

    // 3: output back-pressure with a competing operand
    out_ready = 1'b0;
    send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 0);
    wait_result("t3", 8'h0A, 1'b0);
    step();
    in_valid = 1'b1;
    din      = 8'h77;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3_hold_valid", 32'(out_valid), 32'(1));
      chk("t3_hold_acc",   32'(acc_out),   32'(8'h0A));
      chk("t3_hold_ready", 32'(in_ready),  32'(0));
      step();
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    step();
    @(negedge clk);
    chk("t3_after_busy",  32'(busy),      32'(0));
    chk("t3_after_valid", 32'(out_valid), 32'(0));
    step();

    // 4: bubbles between operands
    send(8'h03, 2); send(8'h04, 2); send(8'h05, 2); send(8'h06, 2);
    wait_result("t4", 8'h12, 1'b0);
    step();

    // 5: clr mid-accumulation rejects the operand in the clr cycle
    send(8'h11, 0); send(8'h22, 0);
    clr      = 1'b1;
    in_valid = 1'b1;
    din      = 8'h33;
    @(negedge clk);
    chk("t5_clr_ready", 32'(in_ready), 32'(0));
    step();
    clr      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("t5_clr_busy", 32'(busy),    32'(0));
    chk("t5_clr_acc",  32'(acc_out), 32'(8'h00));
    step();
    send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 0);
    wait_result("t5", 8'h0A, 1'b0);
    step();

    // 6: asynchronous reset between edges, then exactly 256 total
    send(8'h10, 0); send(8'h20, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_busy",  32'(busy),      32'(0));
    chk("t6_rst_valid", 32'(out_valid), 32'(0));
    chk("t6_rst_acc",   32'(acc_out),   32'(8'h00));
    step();
    rst_n = 1'b1;
    #1;
    chk("t6_ready", 32'(in_ready), 32'(1));
    step();
    send(8'h40, 0); send(8'h40, 0); send(8'h40, 0); send(8'h40, 0);
    wait_result("t6", 8'h00, 1'b1);
    step();

    // Randomized traffic, checked cycle by cycle by the compare process
    for (int i = 0; i < 600; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      din       = 8'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      clr       = ($urandom_range(0, 24) == 0);
      step();
    end
    in_valid  = 1'b0;
    clr       = 1'b0;
    out_ready = 1'b1;
    repeat (4) step();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
